// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline stall/flush/redirect controller with interrupt entry
// Merges stage stall requests, applies branch and interrupt redirects, and holds a redirect until the PC stage is free.
module pipe_ctrl #(
  parameter logic [31:0] IRQ_VECTOR = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_if_i,
  input  logic        stallreq_id_i,
  input  logic        stallreq_ex_i,
  input  logic        stallreq_mem_i,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  input  logic [31:0] ex_pc_i,
  input  logic        irq_i,
  output logic [5:0]  stall_o,
  output logic        flush_o,
  output logic        new_pc_valid_o,
  output logic [31:0] new_pc_o,
  output logic [31:0] epc_o,
  output logic        irq_ack_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  logic [1:0]  state;
  logic        pending_valid;
  logic [31:0] pending_pc;
  logic [5:0]  stall;
  logic        ex_adv;
  logic        branch_take;
  logic        pend_rel;
  logic        irq_enter;

  always_comb begin
    if (stallreq_mem_i)     stall = 6'b011111;
    else if (stallreq_ex_i) stall = 6'b001111;
    else if (stallreq_id_i) stall = 6'b000111;
    else if (stallreq_if_i) stall = 6'b000011;
    else                    stall = 6'b000000;
  end

  assign ex_adv      = ~stall[3];
  assign branch_take = ex_adv & branch_flag_i;
  assign pend_rel    = pending_valid & ~stall[0];
  // Interrupt entry only on a fully quiet pipeline with no redirect in flight.
  assign irq_enter   = (state == S_WAIT) & irq_i & ~branch_flag_i & ~pending_valid
                       & (stall == 6'b000000);

  assign stall_o = rst ? stall : 6'b000000;

  always_comb begin
    flush_o        = 1'b0;
    new_pc_valid_o = 1'b0;
    new_pc_o       = 32'h0;
    irq_ack_o      = 1'b0;
    if (rst) begin
      if (branch_take) begin
        flush_o = 1'b1;
        if (!stall[0]) begin
          new_pc_valid_o = 1'b1;
          new_pc_o       = branch_target_i;
        end
      end else if (pend_rel) begin
        flush_o        = 1'b1;
        new_pc_valid_o = 1'b1;
        new_pc_o       = pending_pc;
      end else if (irq_enter) begin
        flush_o        = 1'b1;
        new_pc_valid_o = 1'b1;
        new_pc_o       = IRQ_VECTOR;
        irq_ack_o      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= S_IDLE;
      pending_valid <= 1'b0;
      pending_pc    <= 32'h0;
      epc_o         <= 32'h0;
    end else begin
      // A newer branch always supersedes any parked redirect.
      if (branch_take) begin
        pending_valid <= stall[0];
        if (stall[0]) pending_pc <= branch_target_i;
      end else if (pend_rel) begin
        pending_valid <= 1'b0;
      end

      case (state)
        S_IDLE: if (irq_i) state <= S_WAIT;
        S_WAIT: begin
          if (!irq_i) begin
            state <= S_IDLE;
          end else if (irq_enter) begin
            state <= S_HOLD;
            epc_o <= ex_pc_i;
          end
        end
        S_HOLD: if (!irq_i) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - self-checking bench for pipe_ctrl
// Reference model compares every cycle; directed steps add literal expectations.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sif, sid, sex, smem, br, irq;
  logic [31:0] tgt, expc;
  logic [5:0]  stall_o;
  logic        flush_o, new_pc_valid_o, irq_ack_o;
  logic [31:0] new_pc_o, epc_o;

  int checks = 0;
  int errors = 0;

  pipe_ctrl dut (
    .clk(clk), .rst(rst),
    .stallreq_if_i(sif), .stallreq_id_i(sid), .stallreq_ex_i(sex), .stallreq_mem_i(smem),
    .branch_flag_i(br), .branch_target_i(tgt), .ex_pc_i(expc), .irq_i(irq),
    .stall_o(stall_o), .flush_o(flush_o), .new_pc_valid_o(new_pc_valid_o),
    .new_pc_o(new_pc_o), .epc_o(epc_o), .irq_ack_o(irq_ack_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: irq phase 0 = idle, 1 = requested, 2 = serviced (awaiting deassert).
  bit          m_pend, n_pend;
  logic [31:0] m_ppc, n_ppc, m_epc, n_epc;
  int          m_irq, n_irq;

  initial begin : scoreboard
    int          depth;
    logic [5:0]  e_stall;
    logic        e_flush, e_val, e_ack, pc_free;
    logic [31:0] e_pc;
    m_pend = 0; m_ppc = 0; m_epc = 0; m_irq = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        m_pend = 0; m_ppc = 0; m_epc = 0; m_irq = 0;
        n_pend = 0; n_ppc = 0; n_epc = 0; n_irq = 0;
        chk("rst_stall", stall_o, 0);
        chk("rst_flush", flush_o, 0);
        chk("rst_npv", new_pc_valid_o, 0);
        chk("rst_ack", irq_ack_o, 0);
        chk("rst_epc", epc_o, 0);
      end else begin
        // Number of stopped stages counted from the PC end of the pipe.
        depth   = smem ? 5 : sex ? 4 : sid ? 3 : sif ? 2 : 0;
        e_stall = 6'((1 << depth) - 1);
        pc_free = (depth == 0);
        e_flush = 0; e_val = 0; e_ack = 0; e_pc = 0;
        n_pend = m_pend; n_ppc = m_ppc; n_epc = m_epc; n_irq = m_irq;
        if (depth < 4 && br) begin
          e_flush = 1;
          if (pc_free) begin
            e_val = 1; e_pc = tgt; n_pend = 0;
          end else begin
            n_pend = 1; n_ppc = tgt;
          end
        end else if (m_pend && pc_free) begin
          e_flush = 1; e_val = 1; e_pc = m_ppc; n_pend = 0;
        end else if (m_irq == 1 && irq && depth == 0) begin
          e_flush = 1; e_val = 1; e_pc = 32'h100; e_ack = 1; n_epc = expc; n_irq = 2;
        end
        if (!irq) n_irq = 0;
        else if (m_irq == 0) n_irq = 1;
        chk("stall", stall_o, e_stall);
        chk("flush", flush_o, e_flush);
        chk("npv", new_pc_valid_o, e_val);
        if (e_val) chk("new_pc", new_pc_o, e_pc);
        chk("ack", irq_ack_o, e_ack);
        chk("epc", epc_o, m_epc);
      end
      @(posedge clk);
      if (rst) begin
        m_pend = n_pend; m_ppc = n_ppc; m_epc = n_epc; m_irq = n_irq;
      end
    end
  end

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic i_if, input logic i_id, input logic i_ex, input logic i_mem,
                        input logic i_br, input logic [31:0] i_tgt, input logic [31:0] i_pc,
                        input logic i_irq);
    sif = i_if; sid = i_id; sex = i_ex; smem = i_mem;
    br = i_br; tgt = i_tgt; expc = i_pc; irq = i_irq;
  endtask

  task automatic step(input logic i_if, input logic i_id, input logic i_ex, input logic i_mem,
                      input logic i_br, input logic [31:0] i_tgt, input logic [31:0] i_pc,
                      input logic i_irq);
    next_cyc();
    set_in(i_if, i_id, i_ex, i_mem, i_br, i_tgt, i_pc, i_irq);
    #2;
  endtask

  initial begin
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    chk("lit_reset_stall", stall_o, 0);
    chk("lit_reset_epc", epc_o, 0);
    chk("lit_reset_npv", new_pc_valid_o, 0);
    next_cyc();
    next_cyc();
    rst = 1'b1;

    // Stall priority
    step(1, 0, 0, 1, 0, 0, 0, 0); chk("lit_stall_mem", stall_o, 32'h1f);
    step(1, 0, 0, 0, 0, 0, 0, 0); chk("lit_stall_if", stall_o, 32'h03);
    step(0, 1, 0, 0, 0, 0, 0, 0); chk("lit_stall_id", stall_o, 32'h07);
    step(0, 0, 1, 0, 0, 0, 0, 0); chk("lit_stall_ex", stall_o, 32'h0f);

    // Immediate branch
    step(0, 0, 0, 0, 1, 32'h80, 0, 0);
    chk("lit_imm_flush", flush_o, 1);
    chk("lit_imm_npv", new_pc_valid_o, 1);
    chk("lit_imm_pc", new_pc_o, 32'h80);
    step(0, 0, 0, 0, 0, 0, 0, 0); chk("lit_imm_after", flush_o, 0);

    // Deferred branch behind an IF stall
    step(1, 0, 0, 0, 1, 32'h200, 0, 0);
    chk("lit_def_flush", flush_o, 1);
    chk("lit_def_npv", new_pc_valid_o, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0); chk("lit_def_hold", new_pc_valid_o, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0); chk("lit_def_hold2", flush_o, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("lit_def_rel_npv", new_pc_valid_o, 1);
    chk("lit_def_rel_pc", new_pc_o, 32'h200);
    chk("lit_def_rel_flush", flush_o, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0); chk("lit_def_once", flush_o, 0);

    // Frozen EX ignores the branch until MEM releases
    step(0, 0, 0, 1, 1, 32'h300, 0, 0); chk("lit_frz_flush", flush_o, 0);
    step(0, 0, 0, 1, 1, 32'h300, 0, 0); chk("lit_frz_npv", new_pc_valid_o, 0);
    step(0, 0, 0, 0, 1, 32'h300, 0, 0);
    chk("lit_frz_rel_npv", new_pc_valid_o, 1);
    chk("lit_frz_rel_pc", new_pc_o, 32'h300);
    step(0, 0, 0, 0, 0, 0, 0, 0);

    // Interrupt entry after an EX stall, then no re-entry while level held
    step(0, 0, 1, 0, 0, 0, 32'h40, 1); chk("lit_irq_wait", irq_ack_o, 0);
    step(0, 0, 1, 0, 0, 0, 32'h40, 1); chk("lit_irq_wait2", irq_ack_o, 0);
    step(0, 0, 0, 0, 0, 0, 32'h44, 1);
    chk("lit_irq_ack", irq_ack_o, 1);
    chk("lit_irq_pc", new_pc_o, 32'h100);
    chk("lit_irq_flush", flush_o, 1);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 0, 0, 0, 32'h48, 1);
      chk("lit_irq_noreentry", irq_ack_o, 0);
    end
    chk("lit_irq_epc", epc_o, 32'h44);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 32'h58, 1); chk("lit_irq2_wait", irq_ack_o, 0);
    step(0, 0, 0, 0, 0, 0, 32'h58, 1); chk("lit_irq2_ack", irq_ack_o, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0); chk("lit_irq2_epc", epc_o, 32'h58);

    // Branch while waiting defers the interrupt by one cycle
    step(0, 0, 0, 0, 0, 0, 32'h60, 1);
    step(0, 0, 0, 0, 1, 32'h400, 32'h64, 1);
    chk("lit_brw_ack", irq_ack_o, 0);
    chk("lit_brw_pc", new_pc_o, 32'h400);
    step(0, 0, 0, 0, 0, 0, 32'h400, 1);
    chk("lit_brw_ack2", irq_ack_o, 1);
    chk("lit_brw_pc2", new_pc_o, 32'h100);
    step(0, 0, 0, 0, 0, 0, 0, 0);

    // IRQ dropped while waiting never enters
    step(0, 1, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0); chk("lit_drop_noack", irq_ack_o, 0);

    // Async reset mid-WAIT with a parked redirect
    step(0, 1, 0, 0, 0, 0, 0, 1);
    step(0, 1, 0, 0, 1, 32'h500, 32'h70, 1); chk("lit_ar_park", new_pc_valid_o, 0);
    step(0, 1, 0, 0, 0, 0, 32'h70, 1);
    rst = 1'b0;
    #1;
    chk("lit_ar_stall", stall_o, 0);
    chk("lit_ar_flush", flush_o, 0);
    next_cyc();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    next_cyc();
    rst = 1'b1;
    #2;
    chk("lit_ar_npv", new_pc_valid_o, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, 0, 0, 0, 0);
      chk("lit_ar_quiet_npv", new_pc_valid_o, 0);
      chk("lit_ar_quiet_ack", irq_ack_o, 0);
    end
    chk("lit_ar_epc", epc_o, 0);

    next_cyc();
    next_cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central pipeline controller for the 5-stage RISC-V core.
- Merges per-stage stall requests into the `stall[5:0]` vector consumed by pc_reg, if_id, id_ex, ex_mem and mem_wb.
- Drives the single-wire `flush` and the PC redirect for taken branches/jumps resolved in EX and for external interrupt entry.
- Holds a redirect whose PC update cannot be applied immediately, and runs a small interrupt-entry FSM.

Parameters:
- IRQ_VECTOR, 32'h0000_0100, PC loaded on interrupt entry.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset (0 = reset)
- stallreq_if_i  in  1  instruction bus not ready
- stallreq_id_i  in  1  load-use hazard
- stallreq_ex_i  in  1  multi-cycle ALU op busy
- stallreq_mem_i  in  1  data bus not ready
- branch_flag_i  in  1  taken branch/jump resolved in EX
- branch_target_i  in  32  redirect target
- ex_pc_i  in  32  PC of instruction currently in EX
- irq_i  in  1  level-sensitive external interrupt
- stall_o  out  6  [0]=pc [1]=if [2]=id [3]=ex [4]=mem [5]=wb; 1 = Stop
- flush_o  out  1  clears if_id and id_ex to NOP
- new_pc_valid_o  out  1  pc_reg loads new_pc_o this cycle
- new_pc_o  out  32  redirect PC
- epc_o  out  32  saved PC of interrupted instruction
- irq_ack_o  out  1  one-cycle interrupt-entry pulse

Behaviour:
- Reset (rst=0, asynchronous): FSM=IDLE, pending_valid=0, pending_pc=0, epc_o=0; all combinational outputs 0 while in reset.
- Stall vector (combinational, priority mem > ex > id > if):
  - mem: 6'b011111
  - ex: 6'b001111
  - id: 6'b000111
  - if: 6'b000011
  - else: 6'b000000
- `ex_adv` = (stall_o[3]==0). Branch and IRQ actions occur only when ex_adv=1. branch_flag_i with ex_adv=0 is ignored; EX is frozen, so the branch re-presents.
- Taken branch (ex_adv & branch_flag_i), same cycle:
  - flush_o=1.
  - If stall_o[0]==0: new_pc_valid_o=1, new_pc_o=branch_target_i.
  - Otherwise: pending_pc<=branch_target_i, pending_valid<=1, and no new_pc_valid.
- Pending redirect:
  - In any cycle with pending_valid=1 and stall_o[0]==0: new_pc_valid_o=1, new_pc_o=pending_pc, pending_valid<=0. flush_o=1 in the same cycle to kill the wrong-path fetch.
  - A new taken branch in the same cycle overwrites: new_pc_o=branch_target_i and pending is cleared.
- Interrupt FSM:
  - IDLE: irq_i=1 -> WAIT.
  - WAIT: enter when ex_adv=1, branch_flag_i=0, pending_valid=0, stall_o==0. Otherwise stay. irq_i dropping to 0 in WAIT returns to IDLE with no entry.
  - ENTER (single cycle, combinational on the WAIT-exit cycle): flush_o=1, new_pc_valid_o=1, new_pc_o=IRQ_VECTOR, irq_ack_o=1, epc_o<=ex_pc_i; next state HOLD.
  - HOLD: stay until irq_i=0, then IDLE. This prevents re-entry on a level still high.
- Priority: branch/pending redirect > interrupt entry. A branch in WAIT defers the interrupt; it never drops it.
- flush_o and new_pc_valid_o are never asserted while ex_adv=0, except a pending release, which needs only stall_o[0]=0.
- Latency: stall_o is 0-cycle (combinational). Redirect is 0-cycle when PC is free, otherwise the first cycle stall_o[0] clears.
- Reset mid-operation discards any pending redirect and any interrupt in progress.

Test Plan:
- Stall priority: stallreq_if=1, stallreq_mem=1 -> stall_o=6'b011111. Drop mem, keep if -> 6'b000011. Only id -> 6'b000111.
- Immediate branch: no stalls, branch_flag_i=1, target=32'h80 -> same cycle flush_o=1, new_pc_valid_o=1, new_pc_o=32'h80.
- Deferred branch: stallreq_if=1 for 3 cycles, branch to 32'h200 in cycle 1 -> flush_o in cycle 1 with new_pc_valid_o=0. When stallreq_if drops: new_pc_valid_o=1, new_pc_o=32'h200, flush_o=1 for one cycle.
- Frozen EX: stallreq_mem=1 with branch_flag_i=1 -> no flush_o or new_pc_valid_o until mem releases, then redirect.
- Interrupt: irq_i=1, stallreq_ex=1 for 2 cycles, ex_pc_i=32'h44 at release -> one-cycle irq_ack_o, new_pc_o=32'h100, epc_o=32'h44. irq_i still high for 5 more cycles -> no second ack. irq_i low then high -> new entry.
- Async reset: assert rst=0 mid-WAIT with a pending redirect -> outputs 0 immediately. After release no redirect and no ack occurs without new stimulus.
